// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// The slot record and the data-availability rule live here so every user agrees on them.
package pipeline_pkg;

  // rd is stored at a fixed width. REG_AW must not exceed it.
  localparam int HZ_RD_W  = 8;
  localparam int FWD_NONE = 0;

  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               regwrite;
    logic               is_load;
  } hz_slot_t;

  // A result can be forwarded out of `slot` once it has been produced.
  // ALU results are produced leaving EX. Load data is produced leaving the last MEM stage.
  function automatic logic avail(input logic is_load, input int slot, input int mem_lat);
    return is_load ? (slot >= mem_lat + 1) : (slot >= 1);
  endfunction

  function automatic int fwd_width(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage decode fields in, stall/flush/forward controls out.
// The master side is the pipeline top level and the slave side is the controller.
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
);
  localparam int FWD_W = fwd_width(MEM_LAT + 2);

  logic              hold;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_branch;
  logic              id_taken;

  logic              stall;
  logic              if_id_flush;
  logic [FWD_W-1:0]  ex_fwd_a;
  logic [FWD_W-1:0]  ex_fwd_b;
  logic [FWD_W-1:0]  id_fwd_a;
  logic [FWD_W-1:0]  id_fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, id_branch, id_taken,
    input  stall, if_id_flush, ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b, stall_cnt
  );

  modport slave (
    input  hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, id_branch, id_taken,
    output stall, if_id_flush, ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b, stall_cnt
  );

endinterface

// File: rtl/hazard_src_lookup.sv
// Priority search of the in-flight write table for one source register.
// It returns the youngest producer at or above slot FIRST.
module hazard_src_lookup
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int D      = 3,
  parameter int FIRST  = 0,
  parameter int SW     = 2
)(
  input  hz_slot_t          slots [D],
  input  logic [REG_AW-1:0] src,
  output logic              hit,
  output logic [SW-1:0]     slot,
  output logic              is_load
);

  always_comb begin
    // NOTE: every output is given a default before the loop so no latch is inferred.
    hit     = 1'b0;
    slot    = '0;
    is_load = 1'b0;
    // Scan from oldest to youngest so the lowest-index producer is the one left standing.
    for (int k = D - 1; k >= FIRST; k--) begin
      if (slots[k].valid && slots[k].regwrite && (src != '0) &&
          (slots[k].rd == HZ_RD_W'(src))) begin
        hit     = 1'b1;
        slot    = SW'(k);
        is_load = slots[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and forwarding controller for a MIPS pipeline with MEM_LAT memory stages.
// It tracks every in-flight register write from EX to WB in its own shift table.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
)(
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int D     = MEM_LAT + 2;
  localparam int FWD_W = fwd_width(D);

  hz_slot_t          slots [D];
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [CNT_W-1:0]  cnt;

  logic             ex_hit_a, ex_hit_b, id_hit_a, id_hit_b;
  logic [FWD_W-1:0] ex_slot_a, ex_slot_b, id_slot_a, id_slot_b;
  logic             id_ld_a, id_ld_b;
  logic             unused_ex_ld_a, unused_ex_ld_b;
  logic             stall_a, stall_b, stall, accept;

  hazard_src_lookup #(.REG_AW(REG_AW), .D(D), .FIRST(1), .SW(FWD_W)) u_ex_rs (
    .slots(slots), .src(ex_rs), .hit(ex_hit_a), .slot(ex_slot_a), .is_load(unused_ex_ld_a)
  );
  hazard_src_lookup #(.REG_AW(REG_AW), .D(D), .FIRST(1), .SW(FWD_W)) u_ex_rt (
    .slots(slots), .src(ex_rt), .hit(ex_hit_b), .slot(ex_slot_b), .is_load(unused_ex_ld_b)
  );
  hazard_src_lookup #(.REG_AW(REG_AW), .D(D), .FIRST(0), .SW(FWD_W)) u_id_rs (
    .slots(slots), .src(hz.id_rs), .hit(id_hit_a), .slot(id_slot_a), .is_load(id_ld_a)
  );
  hazard_src_lookup #(.REG_AW(REG_AW), .D(D), .FIRST(0), .SW(FWD_W)) u_id_rt (
    .slots(slots), .src(hz.id_rt), .hit(id_hit_b), .slot(id_slot_b), .is_load(id_ld_b)
  );

  // A branch reads its operands in ID now. Other instructions read them one slot later, in EX.
  function automatic logic src_stall(input logic use_src, input logic hit,
                                     input logic [FWD_W-1:0] slot, input logic is_load,
                                     input logic branch);
    int s;
    s = int'(slot);
    if (!(use_src && hit)) return 1'b0;
    return branch ? !avail(is_load, s, MEM_LAT) : !avail(is_load, s + 1, MEM_LAT);
  endfunction

  function automatic logic [FWD_W-1:0] id_sel(input logic use_src, input logic hit,
                                               input logic src_st, input logic [FWD_W-1:0] slot);
    // WB needs no forward because the register file writes before it reads.
    if (use_src && hit && !src_st && (slot != FWD_W'(D - 1))) return slot;
    return FWD_W'(FWD_NONE);
  endfunction

  always_comb begin
    stall_a = src_stall(hz.id_use_rs, id_hit_a, id_slot_a, id_ld_a, hz.id_branch);
    stall_b = src_stall(hz.id_use_rt, id_hit_b, id_slot_b, id_ld_b, hz.id_branch);
    stall   = hz.id_valid & (stall_a | stall_b);
    accept  = hz.id_valid & ~stall;
  end

  assign hz.stall       = stall;
  assign hz.if_id_flush = hz.id_valid & hz.id_branch & hz.id_taken & ~stall & ~hz.hold;
  assign hz.ex_fwd_a    = ex_hit_a ? ex_slot_a : FWD_W'(FWD_NONE);
  assign hz.ex_fwd_b    = ex_hit_b ? ex_slot_b : FWD_W'(FWD_NONE);
  assign hz.id_fwd_a    = id_sel(hz.id_use_rs, id_hit_a, stall_a, id_slot_a);
  assign hz.id_fwd_b    = id_sel(hz.id_use_rt, id_hit_b, stall_b, id_slot_b);
  assign hz.stall_cnt   = cnt;

  // NOTE: sequential state uses non-blocking assignments so every slot shifts from its pre-edge value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the table is a handful of flops rather than a RAM, so it is cleared here.
      // The asynchronous clear is what drops stall without waiting for a clock edge.
      for (int k = 0; k < D; k++) slots[k] <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      cnt   <= '0;
    end else if (!hz.hold) begin
      for (int k = D - 1; k >= 1; k--) slots[k] <= slots[k-1];
      if (accept) begin
        slots[0] <= '{valid: 1'b1, rd: HZ_RD_W'(hz.id_rd),
                      regwrite: hz.id_regwrite, is_load: hz.id_memread};
        ex_rs    <= hz.id_rs;
        ex_rt    <= hz.id_rt;
      end else begin
        slots[0] <= '0;
        ex_rs    <= '0;
        ex_rt    <= '0;
      end
      if (stall && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

- Parametrised hazard, stall and forwarding controller for the MIPS pipeline. It replaces the fixed-depth hazard-detection and forwarding pair.
- It tracks every in-flight register write from EX through WB in its own shift table, so the top level routes only ID-stage decode fields.
- From that table it issues stalls, bubbles, IF/ID flush, and EX- and ID-stage (branch comparator) forward selects, for any data-memory latency `MEM_LAT`.

## Interface
- `REG_AW`, default 5: register-address width.
- `MEM_LAT`, default 1: data-memory stages (≥1). Tracked slots `D = MEM_LAT+2`.
- `CNT_W`, default 16: stall-counter width.
- `FWD_W`, derived `max(1,$clog2(D))`: forward-select width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `hold`  in  1  global freeze; table does not shift and the counter does not count.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  REG_AW  ID source registers.
- `id_use_rs`, `id_use_rt`  in  1  source actually read.
- `id_rd`  in  REG_AW  resolved destination (after RegDst).
- `id_regwrite`, `id_memread`, `id_branch`  in  1  decoded controls.
- `id_taken`  in  1  branch comparator result from the top level, computed with forwarded operands.
- `stall`  out  1  freeze PC and IF/ID; insert bubble into ID/EX.
- `if_id_flush`  out  1  squash the IF/ID contents.
- `ex_fwd_a`, `ex_fwd_b`  out  FWD_W  EX ALU operand source.
- `id_fwd_a`, `id_fwd_b`  out  FWD_W  ID branch comparator source.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
**Table layout**
- D slots. Each slot holds {valid, rd, regwrite, is_load}.
- Slot 0 is EX. Slots 1..MEM_LAT are MEM stages. Slot D-1 is WB.
- **Shift** on every edge with `hold`=0: slot[k] ← slot[k-1].
- **Slot 0 load** takes the ID fields when `id_valid & ~stall`, otherwise a bubble (valid=0).
- **`hold`=1:** all state is kept.

**Producers**
- A slot is a producer of register r if valid & regwrite & rd==r & r≠0.
- **Data availability:** non-load from slot ≥1; load from slot D-1 only.

**EX forward selects** (`ex_fwd_*`)
- Take the youngest producer (lowest index ≥1) of the EX instruction's rs/rt. The EX instruction's rs/rt are registered alongside slot 0.
- Output its slot index.
- Output 0 when there is no producer: use the ID/EX register value.

**ID forward selects and stall**
- Consider the youngest producer in slots 0..D-1 of each used ID source. Let s be its slot.
- **Non-branch consumer:** stall iff the producer is not available at slot s+1.
- **Branch consumer:** stall iff the producer is not available at slot s now. Slot 0 is never available.
- Otherwise `id_fwd_*` = s, or 0 when s = D-1 or there is no producer. The register file is write-before-read.
- `stall` is the OR over both sources, gated by `id_valid`.
- **Flush:** `if_id_flush = id_valid & id_branch & id_taken & ~stall & ~hold`.
- **Counter:** `stall_cnt` increments when `stall & ~hold`, and saturates at all-ones.

## Timing
- Reset: all slots invalid; `stall_cnt`=0. Therefore `stall`=0, `if_id_flush`=0 (with `id_valid`=0) and all `*_fwd_*`=0.
- Outputs are combinational from table state plus ID inputs. There are no registered outputs except `stall_cnt`.
- Load-use with MEM_LAT=1: exactly 1 stall cycle. In general, load-use stall = MEM_LAT cycles.
- Branch after ALU producer: 1 stall cycle. Branch after load: MEM_LAT+1 cycles.
- **Simultaneous `stall` and `id_taken`:** no flush. The branch re-evaluates next cycle.
- **Duplicate rd in several slots:** the youngest wins.
- **rd = 0:** never forwarded and never stalls.
- **`reset` asserted mid-stall:** the table clears immediately (async) and `stall` deasserts in the same cycle.

## Structure
- **`pipeline_pkg` contents:**
  - slot struct `hz_slot_t`;
  - `FWD_NONE = 0`;
  - function `avail(is_load, slot, MEM_LAT)`.
- **One sub-module, `hazard_src_lookup`:** a priority search returning {hit, slot, is_load} for one register.
  - Instantiated four times: EX rs, EX rt, ID rs, ID rt.

## Test plan
1. **Load-use stall.** MEM_LAT=1: `lw r2` then `add r3,r2,r4`.
   - `stall`=1 for exactly 1 cycle.
   - Then `ex_fwd_a`=2 (WB slot) when the add is in EX.
2. **Back-to-back ALU forwarding.** `add r5`, `sub r6,r5,r5`: no stall; `ex_fwd_a`=`ex_fwd_b`=1.
3. **Load-use stall, deeper memory.** MEM_LAT=2, `lw r7` then `or r8,r7,r0`: `stall` high 2 cycles; `stall_cnt`=2.
4. **Branch after ALU producer.** `add r1`, then `beq r1,r9` taken:
   - 1 stall cycle;
   - then `id_fwd_a`=1 and `if_id_flush`=1 for one cycle.
5. **Zero register and hold.**
   - Writes to r0 followed by a consumer of r0: no stall, all fwd=0.
   - `hold`=1 for 3 cycles mid-stall: table frozen and `stall_cnt` unchanged.
6. **Async reset mid-stall.** `reset` low during a load-use stall: outputs drop to 0 asynchronously; `stall_cnt`=0.
